// File: rtl/mdu_iterative_if.sv
// Request/result bundle between the execute-stage control path and the
// iterative multiply/divide unit.
interface mdu_iterative_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       MDCtrl;
    logic             Sign;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, MDCtrl, Sign, in1, in2,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, MDCtrl, Sign, in1, in2,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a final sign-fix/write cycle.
module mdu_iterative #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mdu_iterative_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_d;

    logic             accept_md_c, accept_mt_c, calc_c, fix_c, last_c;
    logic [CW-1:0]    cnt;
    logic             op_div, neg_res, neg_rem, div0;
    logic [WIDTH-1:0] a_orig, b_mag;
    // acc_hi holds the running partial product high part or the remainder;
    // acc_lo holds the multiplier being shifted out or the quotient being built.
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0]   a_mag_c, b_mag_c;
    logic [WIDTH:0]     mul_sum_c, div_shift_c, div_diff_c;
    logic               div_ge_c;
    logic [WIDTH:0]     hi_step_c;
    logic [WIDTH-1:0]   lo_step_c;
    logic [2*WIDTH-1:0] prod_c, prod_fix_c;
    logic [WIDTH-1:0]   quo_fix_c, rem_fix_c, hi_fix_c, lo_fix_c;

    assign last_c = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state and control strobes
    always_comb begin
        state_d     = state;
        accept_md_c = 1'b0;
        accept_mt_c = 1'b0;
        calc_c      = 1'b0;
        fix_c       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.MDCtrl[1]) begin
                        accept_mt_c = 1'b1;
                    end else begin
                        accept_md_c = 1'b1;
                        state_d     = CALC;
                    end
                end
            end
            CALC: begin
                calc_c = 1'b1;
                if (last_c) state_d = FIX;
            end
            FIX: begin
                fix_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes; 0x80000000 maps cleanly to unsigned 2^(WIDTH-1)
    always_comb begin
        a_mag_c = (bus.Sign && bus.in1[WIDTH-1]) ? WIDTH'(-bus.in1) : bus.in1;
        b_mag_c = (bus.Sign && bus.in2[WIDTH-1]) ? WIDTH'(-bus.in2) : bus.in2;
    end

    // One iteration step for multiply or divide
    always_comb begin
        mul_sum_c   = acc_lo[0] ? (acc_hi + {1'b0, b_mag}) : acc_hi;
        div_shift_c = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_ge_c    = (div_shift_c >= {1'b0, b_mag});
        div_diff_c  = div_shift_c - {1'b0, b_mag};
        if (op_div) begin
            hi_step_c = {1'b0, (div_ge_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0])};
            lo_step_c = {acc_lo[WIDTH-2:0], div_ge_c};
        end else begin
            hi_step_c = {1'b0, mul_sum_c[WIDTH:1]};
            lo_step_c = {mul_sum_c[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and special-case selection for the final write
    always_comb begin
        prod_c     = {acc_hi[WIDTH-1:0], acc_lo};
        prod_fix_c = neg_res ? (2*WIDTH)'(-prod_c) : prod_c;
        quo_fix_c  = neg_res ? WIDTH'(-acc_lo) : acc_lo;
        rem_fix_c  = neg_rem ? WIDTH'(-acc_hi[WIDTH-1:0]) : acc_hi[WIDTH-1:0];
        if (!op_div) begin
            hi_fix_c = prod_fix_c[2*WIDTH-1:WIDTH];
            lo_fix_c = prod_fix_c[WIDTH-1:0];
        end else if (div0) begin
            hi_fix_c = a_orig;
            lo_fix_c = '1;
        end else begin
            hi_fix_c = rem_fix_c;
            lo_fix_c = quo_fix_c;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div0     <= 1'b0;
            a_orig   <= '0;
            b_mag    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.busy <= (state_d != IDLE);
            bus.done <= fix_c;
            if (accept_mt_c) begin
                if (bus.MDCtrl[0]) bus.lo <= bus.in1;
                else               bus.hi <= bus.in1;
            end
            if (accept_md_c) begin
                op_div  <= bus.MDCtrl[0];
                neg_res <= bus.Sign & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
                neg_rem <= bus.Sign & bus.in1[WIDTH-1];
                div0    <= (bus.in2 == '0);
                a_orig  <= bus.in1;
                b_mag   <= b_mag_c;
                acc_hi  <= '0;
                acc_lo  <= a_mag_c;
                cnt     <= '0;
            end
            if (calc_c) begin
                cnt    <= cnt + CW'(1);
                acc_hi <= hi_step_c;
                acc_lo <= lo_step_c;
            end
            if (fix_c) begin
                bus.hi <= hi_fix_c;
                bus.lo <= lo_fix_c;
            end
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: expected HI/LO pairs are queued at
// issue time and compared when the done pulse arrives.
module tb_mdu_iterative;
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    mdu_iterative_if #(.WIDTH(32)) bus ();
    mdu_iterative #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic res_t model(input logic [1:0] op, input logic s,
                                   input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic signed [63:0] sp;
        logic [63:0] up;
        if (op == 2'b00) begin
            if (s) begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r = sp;
            end else begin
                up = {32'd0, a} * {32'd0, b};
                r = up;
            end
        end else if (b == 32'd0) begin
            r.hi = a;
            r.lo = 32'hFFFF_FFFF;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.hi = 32'd0;
            r.lo = 32'h8000_0000;
        end else if (s) begin
            r.lo = $signed(a) / $signed(b);
            r.hi = $signed(a) % $signed(b);
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.MDCtrl = op;
        bus.Sign   = s;
        bus.in1    = a;
        bus.in2    = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in1   = $urandom;
        bus.in2   = $urandom;
        bus.Sign  = ~s;
    endtask

    task automatic wait_done(output int lat);
        int i = 0;
        lat = -1;
        while (lat < 0 && i < 40) begin
            i++;
            @(posedge clk); #1;
            if (bus.done === 1'b1) lat = i;
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: hi=%h lo=%h busy=%b done=%b, want all zero",
                         c, bus.hi, bus.lo, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [1:0]  ops [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        logic        sgn [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] av  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'h8000_0000};
        logic [31:0] bv  [6] = '{32'd3, 32'd3, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        res_t        ev  [6] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFA}, {32'h2, 32'hFFFF_FFFA},
                                 {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd2, 32'd14},
                                 {32'h1234, 32'hFFFF_FFFF}, {32'd0, 32'h8000_0000}};
        int lat;
        res_t e;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(ev[k]);
            issue(ops[k], sgn[k], av[k], bv[k]);
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL op%0d_busy_after_accept: busy=%b done=%b, want 1/0", k, bus.busy, bus.done);
            end
            wait_done(lat);
            checks++;
            if (lat != 33) begin
                errors++;
                $display("FAIL op%0d_latency: got %0d cycles, want 33", k, lat);
            end
            e = exp_q.pop_front();
            checks++;
            if (bus.hi !== e.hi || bus.lo !== e.lo) begin
                errors++;
                $display("FAIL op%0d_result: hi=%h lo=%h, want hi=%h lo=%h", k, bus.hi, bus.lo, e.hi, e.lo);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL op%0d_busy_at_done: busy=%b, want 0", k, bus.busy);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.hi !== e.hi || bus.lo !== e.lo) begin
                errors++;
                $display("FAIL op%0d_done_pulse_width: done=%b hi=%h lo=%h, want 0 and held result",
                         k, bus.done, bus.hi, bus.lo);
            end
        end
    endtask

    task automatic test_mthi_while_busy();
        int lat;
        res_t e;
        exp_q.push_back('{hi: 32'h12, lo: 32'h3456_7800});
        issue(2'b00, 1'b0, 32'h1234_5678, 32'h100);
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.MDCtrl = 2'b10; bus.in1 = 32'hAAAA;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.hi === 32'hAAAA) begin
            errors++;
            $display("FAIL mthi_busy_ignored: hi=%h, want unchanged", bus.hi);
        end
        wait_done(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat < 0 || bus.hi !== e.hi || bus.lo !== e.lo) begin
            errors++;
            $display("FAIL mthi_busy_result: lat=%0d hi=%h lo=%h, want hi=%h lo=%h", lat, bus.hi, bus.lo, e.hi, e.lo);
        end
    endtask

    task automatic test_move();
        logic [31:0] hi_before;
        @(posedge clk); #1;
        hi_before = bus.hi;
        bus.start = 1'b1; bus.MDCtrl = 2'b11; bus.in1 = 32'h55;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.lo !== 32'h55 || bus.hi !== hi_before || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo_idle: lo=%h hi=%h busy=%b done=%b, want lo=00000055 hi=%h busy=0 done=0",
                     bus.lo, bus.hi, bus.busy, bus.done, hi_before);
        end
        bus.start = 1'b1; bus.MDCtrl = 2'b10; bus.in1 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h55 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mthi_idle: hi=%h lo=%h busy=%b done=%b, want hi=deadbeef lo=00000055 busy=0 done=0",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen = 0;
        res_t e;
        issue(2'b01, 1'b0, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, want all zero", bus.busy, bus.done, bus.hi, bus.lo);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d cycles with done/busy set, want 0", seen);
        end
        exp_q.push_back('{hi: 32'd0, lo: 32'd49});
        issue(2'b00, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFF9);
        wait_done(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat != 33 || bus.hi !== e.hi || bus.lo !== e.lo) begin
            errors++;
            $display("FAIL mult_after_reset: lat=%0d hi=%h lo=%h, want 33 hi=%h lo=%h", lat, bus.hi, bus.lo, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] corners [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        logic [1:0]  op;
        logic        s;
        logic [31:0] a, b;
        int lat;
        res_t e;
        for (int k = 0; k < 10; k++) begin
            op = 2'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            exp_q.push_back(model(op, s, a, b));
            issue(op, s, a, b);
            wait_done(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat != 33 || bus.hi !== e.hi || bus.lo !== e.lo) begin
                errors++;
                $display("FAIL b2b%0d op=%0d s=%b a=%h b=%h: lat=%0d hi=%h lo=%h, want 33 hi=%h lo=%h",
                         k, op, s, a, b, lat, bus.hi, bus.lo, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.MDCtrl = 2'b00;
        bus.Sign   = 1'b0;
        bus.in1    = '0;
        bus.in2    = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        test_reset();
        test_muldiv();
        test_mthi_while_busy();
        test_move();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
